// File: rtl/vga_uart_pkg.sv
// Shared constants and FSM state type for the VGA UART byte protocol.
package vga_uart_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'h80;
  localparam int unsigned FB_W        = 320;
  localparam int unsigned FB_H        = 240;
  localparam int unsigned NUM_PIXELS  = FB_W * FB_H;
  localparam int unsigned ADDR_W      = $clog2(NUM_PIXELS);
  localparam int unsigned CLK_PER_BIT = 50;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_SYNC,
    ST_SEND_PIX,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/uart_tx.sv
// UART 8N1 byte transmitter with trailing idle-high gap bits.
// ready_c rises in the final cycle of the last gap bit so bytes chain with no dead cycle.
module uart_tx #(
  parameter int unsigned CLK_PER_BIT = 50,
  parameter int unsigned GAP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready_c,
  output logic       tx
);

  localparam int unsigned LAST_BIT = 9 + GAP_BITS;
  localparam int unsigned CNT_W    = $clog2(CLK_PER_BIT + 1);
  localparam int unsigned BIT_W    = $clog2(LAST_BIT + 1);

  logic             active;
  logic [CNT_W-1:0] clk_cnt;
  logic [BIT_W-1:0] bit_idx;
  logic [7:0]       shreg;
  logic             bit_end_c;

  assign bit_end_c = (clk_cnt == CNT_W'(CLK_PER_BIT - 1));
  assign ready_c   = !active || (bit_end_c && (bit_idx == BIT_W'(LAST_BIT)));

  // Bit timer, bit index and shift register; bit_idx 0 = start, 1..8 = data, 9 = stop, then gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (valid && ready_c) begin
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= data;
      tx      <= 1'b0;
    end else if (active) begin
      if (bit_end_c) begin
        clk_cnt <= '0;
        if (bit_idx == BIT_W'(LAST_BIT)) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_idx <= bit_idx + BIT_W'(1);
          if (bit_idx < BIT_W'(8)) begin
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end else begin
            tx <= 1'b1;
          end
        end
      end else begin
        clk_cnt <= clk_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_uart_tx.sv
// Frame-buffer readback streamer: sync byte 0x80 then every pixel (MSB cleared) over UART.
module fb_uart_tx
  import vga_uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = vga_uart_pkg::CLK_PER_BIT,
  parameter int unsigned NUM_PIXELS  = vga_uart_pkg::NUM_PIXELS,
  parameter int unsigned ADDR_W      = vga_uart_pkg::ADDR_W,
  parameter int unsigned GAP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              tx
);

  // One extra bit so next-pixel lookahead past the last index cannot wrap.
  localparam int unsigned IDX_W = ADDR_W + 1;

  state_e           state, state_d;
  logic [IDX_W-1:0] pix_idx, pix_idx_d;
  logic             busy_d, done_d;
  logic             byte_valid_c, byte_ready_c;
  logic [7:0]       byte_data_c;
  logic             fetch_c;
  logic [IDX_W-1:0] fetch_idx_c;
  logic             rd_req, rd_vld;
  logic [7:0]       hold;

  uart_tx #(
    .CLK_PER_BIT(CLK_PER_BIT),
    .GAP_BITS   (GAP_BITS)
  ) u_uart_tx (
    .clk    (clk),
    .rst    (rst),
    .valid  (byte_valid_c),
    .data   (byte_data_c),
    .ready_c(byte_ready_c),
    .tx     (tx)
  );

  // Next state, byte hand-off and prefetch of the following pixel on each byte's start.
  always_comb begin
    state_d      = state;
    pix_idx_d    = pix_idx;
    busy_d       = busy;
    done_d       = 1'b0;
    byte_valid_c = 1'b0;
    byte_data_c  = hold;
    fetch_c      = 1'b0;
    fetch_idx_c  = '0;
    case (state)
      ST_IDLE, ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          state_d      = ST_SEND_SYNC;
          busy_d       = 1'b1;
          byte_valid_c = 1'b1;
          byte_data_c  = SYNC_BYTE;
          pix_idx_d    = '0;
          fetch_c      = 1'b1;
          fetch_idx_c  = '0;
        end
      end
      ST_SEND_SYNC: begin
        if (byte_ready_c) begin
          state_d      = ST_SEND_PIX;
          byte_valid_c = 1'b1;
          pix_idx_d    = '0;
          fetch_idx_c  = IDX_W'(1);
          fetch_c      = (fetch_idx_c < IDX_W'(NUM_PIXELS));
        end
      end
      ST_SEND_PIX: begin
        if (byte_ready_c) begin
          if (pix_idx == IDX_W'(NUM_PIXELS - 1)) begin
            state_d = ST_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            byte_valid_c = 1'b1;
            pix_idx_d    = pix_idx + IDX_W'(1);
            fetch_idx_c  = pix_idx + IDX_W'(2);
            fetch_c      = (fetch_idx_c < IDX_W'(NUM_PIXELS));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, status outputs, read address and one-cycle-latency capture into the holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pix_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_addr <= '0;
      rd_req   <= 1'b0;
      rd_vld   <= 1'b0;
      hold     <= '0;
    end else begin
      state   <= state_d;
      pix_idx <= pix_idx_d;
      busy    <= busy_d;
      done    <= done_d;
      rd_req  <= fetch_c;
      rd_vld  <= rd_req;
      if (fetch_c) mem_addr <= fetch_idx_c[ADDR_W-1:0];
      if (rd_vld)  hold     <= mem_rdata & 8'h7F;
    end
  end

endmodule

// File: tb/tb_fb_uart_tx.sv
// Directed bench for fb_uart_tx with a 4-pixel frame buffer and a UART line decoder.
module tb_fb_uart_tx;

  localparam int unsigned ADDR_W  = 17;
  localparam int          BYTE_CY = 550;  // (10 + 1 gap) * 50
  localparam int          FRAME   = 2750; // 5 bytes
  localparam int          LOG_N   = 6000;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              tx;

  logic [7:0]        mem [0:3];
  logic              tx_log   [0:LOG_N-1];
  logic              busy_log [0:LOG_N-1];
  logic              done_log [0:LOG_N-1];
  logic [ADDR_W-1:0] addr_log [0:LOG_N-1];
  logic [7:0]        rx_q [$];
  logic [7:0]        exp_b [0:4];

  int errors = 0;
  int checks = 0;

  fb_uart_tx #(
    .CLK_PER_BIT(50),
    .NUM_PIXELS (4),
    .ADDR_W     (ADDR_W),
    .GAP_BITS   (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read frame buffer, 1-cycle latency; out-of-range reads return a marker.
  always @(posedge clk) begin
    if (mem_addr < ADDR_W'(4)) mem_rdata <= mem[mem_addr[1:0]];
    else                       mem_rdata <= 8'hEE;
  end

  // Pulse start, then log outputs once per cycle; log[i] is the value after edge k+i.
  task automatic run_log(input int ncyc, input int start_at, input int rst_at);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      tx_log[i]   = tx;
      busy_log[i] = busy;
      done_log[i] = done;
      addr_log[i] = mem_addr;
      start = (i == start_at);
      rst   = (i == rst_at);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  // Mid-bit sampling UART decoder over the log; a bad stop bit yields an X byte.
  task automatic decode(input int from, input int to);
    int i;
    logic [7:0] b;
    rx_q.delete();
    i = from;
    while (i + 475 < to) begin
      if (tx_log[i] === 1'b0) begin
        for (int j = 0; j < 8; j++) b[j] = tx_log[i + 75 + 50 * j];
        if (tx_log[i + 475] !== 1'b1) b = 8'hxx;
        rx_q.push_back(b);
        i += 475;
      end else begin
        i++;
      end
    end
  endtask

  // Counts cycles whose tx differs from the ideal back-to-back waveform of exp_b.
  function automatic int wave_err(input int from, input int nbytes);
    int e;
    int bp;
    logic want;
    e = 0;
    for (int n = 0; n < nbytes; n++) begin
      for (int c = 0; c < BYTE_CY; c++) begin
        bp = c / 50;
        if (bp == 0)      want = 1'b0;
        else if (bp <= 8) want = exp_b[n][bp-1];
        else              want = 1'b1;
        if (tx_log[from + n * BYTE_CY + c] !== want) e++;
      end
    end
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_frame;
    int first_done;
    int n_done;
    int busy_bad;
    logic [7:0] got;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    exp_b[0] = 8'h80; exp_b[1] = 8'h12; exp_b[2] = 8'h34; exp_b[3] = 8'h56; exp_b[4] = 8'h78;
    run_log(2800, -1, -1);
    checks++; if (tx_log[0] !== 1'b0) begin errors++; $display("FAIL frame_first_start tx got %b want 0", tx_log[0]); end
    checks++; if (busy_log[0] !== 1'b1) begin errors++; $display("FAIL frame_busy_rise got %b want 1", busy_log[0]); end
    decode(0, 2800);
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL frame_nbytes got %0d want 5", rx_q.size()); end
    for (int j = 0; j < 5; j++) begin
      got = (j < rx_q.size()) ? rx_q[j] : 8'hxx;
      checks++; if (got !== exp_b[j]) begin errors++; $display("FAIL frame_byte%0d got %02h want %02h", j, got, exp_b[j]); end
    end
    first_done = -1; n_done = 0; busy_bad = 0;
    for (int i = 0; i < 2800; i++) begin
      if (done_log[i] === 1'b1) begin n_done++; if (first_done < 0) first_done = i; end
      if (i < FRAME && busy_log[i] !== 1'b1) busy_bad++;
    end
    checks++; if (first_done != FRAME) begin errors++; $display("FAIL frame_done_time got %0d want %0d", first_done, FRAME); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", n_done); end
    checks++; if (busy_log[FRAME] !== 1'b0) begin errors++; $display("FAIL frame_busy_at_done got %b want 0", busy_log[FRAME]); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL frame_busy_hold low_cycles got %0d want 0", busy_bad); end
    checks++; if (wave_err(0, 5) != 0) begin errors++; $display("FAIL frame_bit_widths bad_cycles got %0d want 0", wave_err(0, 5)); end
    checks++; if (tx_log[FRAME + 10] !== 1'b1) begin errors++; $display("FAIL frame_idle_after got %b want 1", tx_log[FRAME + 10]); end
  endtask

  task automatic test_msb_clear;
    logic [7:0] got;
    mem[0] = 8'hFF; mem[1] = 8'h80; mem[2] = 8'hAB; mem[3] = 8'h00;
    exp_b[0] = 8'h80; exp_b[1] = 8'h7F; exp_b[2] = 8'h00; exp_b[3] = 8'h2B; exp_b[4] = 8'h00;
    run_log(2800, -1, -1);
    decode(0, 2800);
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL msb_nbytes got %0d want 5", rx_q.size()); end
    for (int j = 0; j < 5; j++) begin
      got = (j < rx_q.size()) ? rx_q[j] : 8'hxx;
      checks++; if (got !== exp_b[j]) begin errors++; $display("FAIL msb_byte%0d got %02h want %02h", j, got, exp_b[j]); end
    end
    checks++; if (wave_err(0, 5) != 0) begin errors++; $display("FAIL msb_wave bad_cycles got %0d want 0", wave_err(0, 5)); end
  endtask

  task automatic test_start_while_busy;
    int n_done;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    exp_b[0] = 8'h80; exp_b[1] = 8'h12; exp_b[2] = 8'h34; exp_b[3] = 8'h56; exp_b[4] = 8'h78;
    run_log(2800, 1000, -1);
    checks++; if (wave_err(0, 5) != 0) begin errors++; $display("FAIL busy_start_wave bad_cycles got %0d want 0", wave_err(0, 5)); end
    n_done = 0;
    for (int i = 0; i < 2800; i++) if (done_log[i] === 1'b1) n_done++;
    checks++; if (n_done != 1 || done_log[FRAME] !== 1'b1) begin
      errors++; $display("FAIL busy_start_done count got %0d at_expected=%b want 1 and 1", n_done, done_log[FRAME]);
    end
  endtask

  task automatic test_reset_mid_byte;
    int bad;
    logic [7:0] got;
    // Pixel 2 is byte 3; its data bit 3 spans log 1850..1899. Reset is sampled at edge k+1871.
    run_log(2000, -1, 1870);
    checks++; if (tx_log[1870] !== 1'b0) begin errors++; $display("FAIL rst_mid_pre_tx got %b want 0", tx_log[1870]); end
    checks++; if (tx_log[1871] !== 1'b1 || busy_log[1871] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after tx=%b busy=%b want tx=1 busy=0", tx_log[1871], busy_log[1871]);
    end
    checks++; if (addr_log[1871] !== '0 || done_log[1871] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_addr_done addr=%0d done=%b want 0 0", addr_log[1871], done_log[1871]);
    end
    bad = 0;
    for (int i = 1871; i < 2000; i++) if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0 || done_log[i] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_stays_idle bad_cycles got %0d want 0", bad); end
    run_log(2800, -1, -1);
    decode(0, 2800);
    for (int j = 0; j < 5; j++) begin
      got = (j < rx_q.size()) ? rx_q[j] : 8'hxx;
      checks++; if (got !== exp_b[j]) begin errors++; $display("FAIL rst_restart_byte%0d got %02h want %02h", j, got, exp_b[j]); end
    end
    checks++; if (done_log[FRAME] !== 1'b1) begin errors++; $display("FAIL rst_restart_done got %b want 1", done_log[FRAME]); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] got;
    // Start raised during the done cycle (log index 2750), sampled at the following edge.
    run_log(5600, FRAME, -1);
    checks++; if (done_log[FRAME] !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b want 1", done_log[FRAME]); end
    checks++; if (tx_log[FRAME + 1] !== 1'b0 || busy_log[FRAME + 1] !== 1'b1) begin
      errors++; $display("FAIL b2b_restart tx=%b busy=%b want tx=0 busy=1", tx_log[FRAME + 1], busy_log[FRAME + 1]);
    end
    decode(FRAME + 1, 5600);
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL b2b_nbytes got %0d want 5", rx_q.size()); end
    for (int j = 0; j < 5; j++) begin
      got = (j < rx_q.size()) ? rx_q[j] : 8'hxx;
      checks++; if (got !== exp_b[j]) begin errors++; $display("FAIL b2b_byte%0d got %02h want %02h", j, got, exp_b[j]); end
    end
    checks++; if (wave_err(FRAME + 1, 5) != 0) begin errors++; $display("FAIL b2b_wave bad_cycles got %0d want 0", wave_err(FRAME + 1, 5)); end
    checks++; if (done_log[2 * FRAME + 1] !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", done_log[2 * FRAME + 1]); end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    test_reset;
    test_frame;
    test_msb_clear;
    test_start_while_busy;
    test_reset_mid_byte;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
